// File: rtl/multicycle_control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_sequencer: multi-cycle instruction control sequencer. |
// | Optional feature macro: CU_ILLEGAL_TRAP_EN. Revision: 1.0                 |
// +--------------------------------------------------------------------------+
module multicycle_control_sequencer #(
    parameter int CW_BITS   = 29,
    parameter int LIT_W     = 64,
    parameter int STALL_MAX = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        instruction,
    input  logic [4:0]         status,
    input  logic               stall,
    output logic [CW_BITS-1:0] control_word,
    output logic [LIT_W-1:0]   literal,
    output logic               cw_valid,
    output logic               stall_err
);

    localparam int                CNT_W       = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0]  C_STALL_MAX = CNT_W'(STALL_MAX);
    localparam logic [CNT_W-1:0]  C_STALL_PRE = CNT_W'(STALL_MAX - 1);
`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit                C_TRAP_EN   = 1'b1;
`else
    localparam bit                C_TRAP_EN   = 1'b0;
`endif
    localparam int C_RW = 0, C_MW = 1, C_MR = 2, C_IMM = 3, C_PC = 4, C_SEL = 5, C_LNK = 6, C_SF = 7;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EX0 = 2'd1, S_EX1 = 2'd2, S_TRAP = 2'd3} state_t;
    typedef enum logic [3:0] {K_D, K_IARITH, K_ILOGIC, K_IW, K_R, K_B, K_BCOND, K_BL, K_CBZ, K_BR, K_ILL} kind_t;

    // Branch group keyed by opcode[10:8], everything else by opcode[4:2].
    function automatic kind_t f_kind(input logic [31:0] ins);
        kind_t k;
        k = K_ILL;
        if (ins[26]) begin
            case (ins[31:29])
                3'b000:  k = K_B;
                3'b010:  k = K_BCOND;
                3'b100:  k = K_BL;
                3'b101:  k = K_CBZ;
                3'b110:  k = K_BR;
                default: k = K_ILL;
            endcase
        end else begin
            case (ins[25:23])
                3'b000:  k = K_D;
                3'b010:  k = K_IARITH;
                3'b100:  k = K_ILOGIC;
                3'b101:  k = K_IW;
                3'b110:  k = K_R;
                default: k = K_ILL;
            endcase
        end
        return k;
    endfunction

    // f = {V,C,N,Z}
    function automatic logic f_cond(input logic [3:0] c, input logic [3:0] f);
        logic v, cy, n, z;
        {v, cy, n, z} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return ~z;
            4'd2:    return cy;
            4'd3:    return ~cy;
            4'd4:    return n;
            4'd5:    return ~n;
            4'd6:    return v;
            4'd7:    return ~v;
            4'd8:    return cy & ~z;
            4'd9:    return ~(cy & ~z);
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return ~z & (n == v);
            4'd13:   return ~(~z & (n == v));
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic f_two_cycle(input logic [31:0] ins);
        kind_t k;
        k = f_kind(ins);
        return (k == K_D) || (k == K_IW) || (k == K_R);
    endfunction

    function automatic logic [12:0] f_ctrl(input logic [31:0] ins, input logic ex1, input logic [4:0] st);
        logic [12:0] cw;
        kind_t       k;
        cw = '0;
        k  = f_kind(ins);
        case (k)
            K_D: begin
                cw[C_IMM] = 1'b1;
                if (ex1) begin
                    cw[C_MR] = ins[22];
                    cw[C_RW] = ins[22];
                    cw[C_MW] = ~ins[22];
                end
            end
            K_IARITH, K_ILOGIC: begin
                cw[C_RW]  = 1'b1;
                cw[C_IMM] = 1'b1;
            end
            K_IW: begin
                cw[C_IMM] = 1'b1;
                cw[C_RW]  = ex1;
            end
            K_R: begin
                cw[C_RW] = ex1;
                cw[C_SF] = ex1 & ins[29];
            end
            K_B:     cw[C_PC] = 1'b1;
            K_BCOND: cw[C_PC] = f_cond(ins[3:0], st[4:1]);
            K_BL: begin
                cw[C_PC]  = 1'b1;
                cw[C_LNK] = 1'b1;
            end
            K_CBZ:   cw[C_PC] = st[0] ^ ins[24];
            K_BR: begin
                cw[C_PC]  = 1'b1;
                cw[C_SEL] = 1'b1;
            end
            default: cw = '0;
        endcase
        if ((k == K_D) || (k == K_IARITH) || (k == K_ILOGIC) || (k == K_IW) || (k == K_R))
            cw[12:8] = ins[31:27];
        return cw;
    endfunction

    function automatic logic [LIT_W-1:0] f_lit(input logic [31:0] ins);
        case (f_kind(ins))
            K_D:                return {{(LIT_W-9){ins[20]}}, ins[20:12]};
            K_IARITH, K_ILOGIC: return {{(LIT_W-12){1'b0}}, ins[21:10]};
            K_IW:               return {{(LIT_W-16){1'b0}}, ins[20:5]} << {ins[22:21], 4'b0000};
            K_B, K_BL:          return {{(LIT_W-28){ins[25]}}, ins[25:0], 2'b00};
            K_BCOND, K_CBZ:     return {{(LIT_W-21){ins[23]}}, ins[23:5], 2'b00};
            default:            return '0;
        endcase
    endfunction

    state_t             r_state, w_state_nx;
    logic [31:0]        r_instr, w_instr_nx;
    logic [12:0]        r_cw, w_cw_nx;
    logic [LIT_W-1:0]   r_lit, w_lit_nx;
    logic [CNT_W-1:0]   r_stall_cnt, w_stall_cnt_nx;
    logic               r_stall_err, w_stall_err_nx;
    logic               w_in_ex;

    assign w_in_ex     = (r_state == S_EX0) || (r_state == S_EX1);
    assign instr_ready = (r_state == S_IDLE);
    assign cw_valid    = w_in_ex & ~stall;
    assign literal     = r_lit;
    assign stall_err   = r_stall_err;

    always_comb begin
        control_word       = '0;
        control_word[12:0] = r_cw;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_instr     <= '0;
            r_cw        <= '0;
            r_lit       <= '0;
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_instr     <= w_instr_nx;
            r_cw        <= w_cw_nx;
            r_lit       <= w_lit_nx;
            r_stall_cnt <= w_stall_cnt_nx;
            r_stall_err <= w_stall_err_nx;
        end
    end

    // Stall holds everything in EX0/EX1; TRAP is left only through reset.
    always_comb begin
        w_state_nx = r_state;
        w_instr_nx = r_instr;
        w_cw_nx    = r_cw;
        w_lit_nx   = r_lit;
        case (r_state)
            S_IDLE: begin
                w_cw_nx  = '0;
                w_lit_nx = '0;
                if (instr_valid) begin
                    w_instr_nx = instruction;
                    if (C_TRAP_EN && (f_kind(instruction) == K_ILL)) begin
                        w_state_nx = S_TRAP;
                    end else begin
                        w_state_nx = S_EX0;
                        w_cw_nx    = f_ctrl(instruction, 1'b0, status);
                        w_lit_nx   = f_lit(instruction);
                    end
                end
            end
            S_EX0: begin
                if (!stall) begin
                    if (f_two_cycle(r_instr)) begin
                        w_state_nx = S_EX1;
                        w_cw_nx    = f_ctrl(r_instr, 1'b1, status);
                    end else begin
                        w_state_nx = S_IDLE;
                        w_cw_nx    = '0;
                        w_lit_nx   = '0;
                    end
                end
            end
            S_EX1: begin
                if (!stall) begin
                    w_state_nx = S_IDLE;
                    w_cw_nx    = '0;
                    w_lit_nx   = '0;
                end
            end
            default: w_state_nx = S_TRAP;
        endcase
    end

    // Error fires on the edge where the saturating count reaches STALL_MAX.
    always_comb begin
        w_stall_cnt_nx = '0;
        w_stall_err_nx = 1'b0;
        if (w_in_ex && stall) begin
            w_stall_cnt_nx = (r_stall_cnt == C_STALL_MAX) ? C_STALL_MAX : r_stall_cnt + 1'b1;
            w_stall_err_nx = (r_stall_cnt == C_STALL_PRE);
        end
    end

endmodule
`default_nettype wire
